// File: rtl/trng_pkg.sv
// Shared constants for the TRNG byte streamer: byte width, default FIFO depth
// and the one-hot TX FSM state encodings.
package trng_pkg;

  localparam int BYTE_W         = 8;
  localparam int FIFO_DEPTH_DEF = 4;

  typedef logic [3:0] tx_state_t;

  localparam tx_state_t S_IDLE      = 4'b0001;
  localparam tx_state_t S_START     = 4'b0010;
  localparam tx_state_t S_WAIT_BUSY = 4'b0100;
  localparam tx_state_t S_WAIT_DONE = 4'b1000;

endpackage

// File: rtl/trng_sync_fifo.sv
// Synchronous byte FIFO, DEPTH x BYTE_W, with occupancy level output.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module trng_sync_fifo
  import trng_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH_DEF,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic [BYTE_W-1:0] i_wdata,
  output logic [BYTE_W-1:0] o_rdata,
  output logic              o_full,
  output logic              o_empty,
  output logic [AW:0]       o_level
);

  logic [DEPTH-1:0][BYTE_W-1:0] r_mem;
  logic [AW-1:0]                r_wptr;
  logic [AW-1:0]                r_rptr;
  logic [AW:0]                  r_level;
  logic                         w_push;
  logic                         w_pop;

  assign o_full  = (r_level == (AW+1)'(DEPTH));
  assign o_empty = (r_level == '0);
  assign o_level = r_level;
  assign o_rdata = r_mem[r_rptr];

  assign w_pop  = i_pop && !o_empty;
  assign w_push = i_push && (!o_full || w_pop);

  // Power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mem   <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= i_wdata;
        r_wptr        <= r_wptr + 1'b1;
      end
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/trng_byte_streamer.sv
// Packs qualified entropy bits LSB-first into bytes, queues them and feeds uart_tx.
// Optional Von Neumann debiasing of the raw bits: define TRNG_VON_NEUMANN_EN.
module trng_byte_streamer
  import trng_pkg::*;
#(
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int FIFO_AW    = $clog2(FIFO_DEPTH)
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_enable,
  input  logic               i_bit_valid,
  input  logic               i_bit,
  input  logic               i_clr_ovf,
  input  logic               i_tx_busy,
  input  logic               i_tx_done,
  output logic               o_tx_start,
  output logic [BYTE_W-1:0]  o_tx_data,
  output logic [FIFO_AW:0]   o_fifo_level,
  output logic               o_overflow
);

  logic              w_raw_valid;
  logic              w_pk_valid;
  logic              w_pk_bit;
  logic [BYTE_W-1:0] r_shift;
  logic [2:0]        r_bit_cnt;
  logic [BYTE_W-1:0] w_byte;
  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic [BYTE_W-1:0] w_head;
  logic              r_ovf;
  logic [BYTE_W-1:0] r_tx_data;
  tx_state_t         r_state;
  tx_state_t         w_next;

  assign w_raw_valid = i_bit_valid && i_enable;

`ifdef TRNG_VON_NEUMANN_EN
  logic r_vn_have;
  logic r_vn_first;

  // Pair 01 -> 0, 10 -> 1: the yielded bit equals the first bit of an unequal pair.
  assign w_pk_valid = w_raw_valid && r_vn_have && (r_vn_first != i_bit);
  assign w_pk_bit   = r_vn_first;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_vn_have  <= 1'b0;
      r_vn_first <= 1'b0;
    end else if (w_raw_valid) begin
      r_vn_have <= !r_vn_have;
      if (!r_vn_have) r_vn_first <= i_bit;
    end
  end
`else
  assign w_pk_valid = w_raw_valid;
  assign w_pk_bit   = i_bit;
`endif

  assign w_byte = {w_pk_bit, r_shift[BYTE_W-1:1]};
  assign w_push = w_pk_valid && (r_bit_cnt == 3'd7);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
    end else if (w_pk_valid) begin
      r_shift   <= w_byte;
      r_bit_cnt <= r_bit_cnt + 1'b1;
    end
  end

  trng_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .AW    (FIFO_AW)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata (w_byte),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (o_fifo_level)
  );

  // A drop-and-clear collision keeps the flag set.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                       r_ovf <= 1'b0;
    else if (w_push && w_full && !w_pop) r_ovf <= 1'b1;
    else if (i_clr_ovf)                 r_ovf <= 1'b0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:      if (!w_empty && !i_tx_busy) w_next = S_START;
      S_START:     w_next = S_WAIT_BUSY;
      S_WAIT_BUSY: if (i_tx_busy) w_next = S_WAIT_DONE;
      S_WAIT_DONE: if (i_tx_done) w_next = S_IDLE;
      default:     w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_pop      = (r_state == S_START);
    o_tx_start = (r_state == S_START);
  end

  // Head is stable from the IDLE->START decision until the pop, so latch it then.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                                 r_tx_data <= '0;
    else if (r_state == S_IDLE && w_next == S_START) r_tx_data <= w_head;
  end

  assign o_tx_data  = r_tx_data;
  assign o_overflow = r_ovf;

endmodule

// File: tb/tb_trng_byte_streamer.sv
// Directed bench for trng_byte_streamer with hand-computed expectations.
// The Von Neumann scenario runs only when TRNG_VON_NEUMANN_EN is defined.
module tb_trng_byte_streamer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable, bit_valid, bit_in, clr_ovf, tx_busy, tx_done;
  logic       tx_start;
  logic [7:0] tx_data;
  logic [2:0] fifo_level;
  logic       overflow;
  int         total = 0;
  int         bad   = 0;

  trng_byte_streamer #(.FIFO_DEPTH(4), .FIFO_AW(2)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_enable     (enable),
    .i_bit_valid  (bit_valid),
    .i_bit        (bit_in),
    .i_clr_ovf    (clr_ovf),
    .i_tx_busy    (tx_busy),
    .i_tx_done    (tx_done),
    .o_tx_start   (tx_start),
    .o_tx_data    (tx_data),
    .o_fifo_level (fifo_level),
    .o_overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    bit_valid = 1'b1;
    bit_in    = b;
    tick();
    bit_valid = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) send_bit(v[i]);
  endtask

  // Emulates uart_tx from S_WAIT_BUSY: busy for one cycle, then a done pulse.
  task automatic uart_ack();
    tx_busy = 1'b1;
    tick();
    tx_busy = 1'b0;
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
  endtask

  // From S_IDLE with UART idle: expect one start carrying exp, then finish the frame.
  task automatic expect_tx(input string tag, input logic [7:0] exp);
    tx_busy = 1'b0;
    tick();
    chk({tag, "_start"}, {7'd0, tx_start}, 8'd1);
    chk({tag, "_data"}, tx_data, exp);
    tick();
    uart_ack();
  endtask

  initial begin
    logic [7:0] v;
    logic       saw_start;
    rst_n = 1'b0; enable = 1'b1; bit_valid = 1'b0; bit_in = 1'b0;
    clr_ovf = 1'b0; tx_busy = 1'b0; tx_done = 1'b0;
    #12;
    chk("rst_start", {7'd0, tx_start}, 8'd0);
    chk("rst_data", tx_data, 8'h00);
    chk("rst_level", {5'd0, fifo_level}, 8'd0);
    chk("rst_ovf", {7'd0, overflow}, 8'd0);
    rst_n = 1'b1;
    tick();

`ifdef TRNG_VON_NEUMANN_EN
    // Raw pairs 01,10,11,00,10 yield 0,1,1; 8 repeats -> 3 bytes.
    tx_busy = 1'b1;
    for (int r = 0; r < 8; r++) begin
      send_bit(1'b0); send_bit(1'b1);
      send_bit(1'b1); send_bit(1'b0);
      send_bit(1'b1); send_bit(1'b1);
      send_bit(1'b0); send_bit(1'b0);
      send_bit(1'b1); send_bit(1'b0);
    end
    chk("vn_level", {5'd0, fifo_level}, 8'd3);
    expect_tx("vn_b0", 8'hB6);
    expect_tx("vn_b1", 8'h6D);
    expect_tx("vn_b2", 8'hDB);
`else
    // 1) 0xA5 with UART idle: level at N+1, start at N+2.
    send_bit(1); send_bit(0); send_bit(1); send_bit(0);
    send_bit(0); send_bit(1); send_bit(0); send_bit(1);
    chk("t1_level", {5'd0, fifo_level}, 8'd1);
    chk("t1_nostart", {7'd0, tx_start}, 8'd0);
    expect_tx("t1", 8'hA5);
    chk("t1_level_after", {5'd0, fifo_level}, 8'd0);

    // 2) Six bytes with UART busy: 0x05 and 0x06 dropped.
    tx_busy = 1'b1;
    for (int k = 1; k <= 4; k++) send_byte(8'(k));
    chk("t2_level4", {5'd0, fifo_level}, 8'd4);
    chk("t2_ovf_clear", {7'd0, overflow}, 8'd0);
    send_byte(8'h05);
    chk("t2_ovf_set", {7'd0, overflow}, 8'd1);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    chk("t2_ovf_cleared", {7'd0, overflow}, 8'd0);
    v = 8'h06;
    for (int i = 0; i < 7; i++) send_bit(v[i]);
    clr_ovf = 1'b1;
    send_bit(v[7]);
    clr_ovf = 1'b0;
    chk("t2_set_wins", {7'd0, overflow}, 8'd1);
    chk("t2_level_still4", {5'd0, fifo_level}, 8'd4);
    for (int k = 1; k <= 4; k++) expect_tx("t2", 8'(k));
    chk("t2_drained", {5'd0, fifo_level}, 8'd0);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;

    // 3) Full FIFO: pop and byte completion in the same cycle.
    tx_busy = 1'b1;
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    v = 8'h55;
    for (int i = 0; i < 7; i++) send_bit(v[i]);
    tx_busy = 1'b0;
    tick();
    chk("t3_start", {7'd0, tx_start}, 8'd1);
    chk("t3_data", tx_data, 8'h11);
    send_bit(v[7]);
    chk("t3_level", {5'd0, fifo_level}, 8'd4);
    chk("t3_ovf", {7'd0, overflow}, 8'd0);
    uart_ack();
    expect_tx("t3_b1", 8'h22);
    expect_tx("t3_b2", 8'h33);
    expect_tx("t3_b3", 8'h44);
    expect_tx("t3_b4", 8'h55);

    // 4) Reset in S_WAIT_DONE with 3 bytes queued.
    tx_busy = 1'b1;
    send_byte(8'h0A); send_byte(8'h0B); send_byte(8'h0C); send_byte(8'h0D);
    tx_busy = 1'b0;
    tick();
    chk("t4_start", tx_data, 8'h0A);
    tick();
    tx_busy = 1'b1;
    tick();
    chk("t4_level3", {5'd0, fifo_level}, 8'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("t4_rst_start", {7'd0, tx_start}, 8'd0);
    chk("t4_rst_data", tx_data, 8'h00);
    chk("t4_rst_level", {5'd0, fifo_level}, 8'd0);
    #2 rst_n = 1'b1;
    tick();
    send_byte(8'h3C);
    saw_start = 1'b0;
    for (int c = 0; c < 4; c++) begin
      saw_start |= tx_start;
      tick();
    end
    chk("t4_no_start_busy", {7'd0, saw_start}, 8'd0);
    chk("t4_level1", {5'd0, fifo_level}, 8'd1);
    expect_tx("t4_after", 8'h3C);

    // 5) Enable low mid-byte: middle nibble ignored.
    send_bit(1); send_bit(0); send_bit(0); send_bit(1);
    enable = 1'b0;
    send_bit(1); send_bit(1); send_bit(1); send_bit(1);
    chk("t5_no_byte", {5'd0, fifo_level}, 8'd0);
    enable = 1'b1;
    send_bit(0); send_bit(1); send_bit(1); send_bit(0);
    chk("t5_one_byte", {5'd0, fifo_level}, 8'd1);
    expect_tx("t5", 8'h69);
    send_byte(8'hC3);
    expect_tx("t5_next", 8'hC3);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
